truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequencer that drives the four inputs A, B, C, D of a 4-input combinational function block through all 16 input vectors, 0000 to 1111. It samples the block's output F on each vector and builds the observed truth table. It compares that table against a programmable 16-bit expected minterm mask and reports pass/fail, the mismatch count and the first failing minterm. It sits between the function block and a host/bench, and replaces open-loop stimulus sweeps with a self-checking, clocked controller.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles each vector is held before F is sampled. Legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep. Accepted only in IDLE or DONE.
- expected  input  16  expected truth table. Bit i = required F for vector i, where i = {A,B,C,D}. Latched on start accept.
- F  input  1  output of the function block under control.
- A, B, C, D  output  1 each  vector driven to the function block. A is the MSB of the index.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high in DONE, held until the next start accept or reset.
- pass  output  1  valid when done. 1 if and only if mismatch_count == 0.
- captured  output  16  observed truth table. Bit i = F sampled for vector i.
- mismatch_count  output  5  number of vectors where F != expected. Range 0..16.
- first_fail  output  4  lowest index that mismatched. Valid when fail_valid = 1.
- fail_valid  output  1  at least one mismatch recorded in the current sweep.

## Operation
- State machine: IDLE, SETTLE, DONE.
- IDLE/DONE + start = 1 → SETTLE. Same edge:
  - idx ← 0, settle_cnt ← 0, exp_q ← expected.
  - captured, mismatch_count, first_fail, fail_valid, pass, done ← 0.
  - busy ← 1.
- SETTLE: {A,B,C,D} = idx, registered. settle_cnt increments each cycle.
- Edge where settle_cnt == SETTLE_CYCLES−1:
  - captured[idx] ← F.
  - If F != exp_q[idx]:
    - mismatch_count += 1.
    - If fail_valid = 0: first_fail ← idx, fail_valid ← 1.
  - If idx == 15: → DONE; busy ← 0; done ← 1; pass ← (final mismatch count == 0, including this vector).
  - Else: idx ← idx+1, settle_cnt ← 0.
- DONE: A..D hold 15 (1111). Results are held stable. start restarts the sweep as from IDLE.
- start while busy: ignored, no effect on the sweep.
- Changes on expected after start accept: ignored, because exp_q is used.
- idx is 4 bits and never wraps inside a sweep; termination is on idx == 15. mismatch_count is 5 bits so 16 mismatches do not overflow.

## Timing
- Reset values (rst = 1 at an edge):
  - State IDLE.
  - A, B, C, D = 0.
  - busy, done, pass, fail_valid = 0.
  - captured = 16'h0000, mismatch_count = 0, first_fail = 0.
  - exp_q, idx, settle_cnt = 0.
- rst has priority over start and over any in-progress sweep. Reset mid-sweep aborts with no partial result retained.
- Start accepted at edge E0:
  - Vector i is driven during cycles E0+1+i·S through E0+(i+1)·S, with S = SETTLE_CYCLES.
  - F is sampled at edge E0+(i+1)·S.
  - done rises after edge E0+16·S, so total latency is 16·S cycles.
- F must settle within S−1 cycles plus combinational delay of the vector change. The function block is purely combinational.
- All outputs are registered. No combinational path from start, F or expected to any output.
- start and rst asserted on the same edge: reset wins, controller stays IDLE.

## Test plan
- Golden model F = minterms {0,1,8,9,10,11,12,14,15}, expected = 16'hDF03, S = 1, start pulse at E0 → done rises after E0+16, pass = 1, captured = 16'hDF03, mismatch_count = 0, fail_valid = 0.
- F stuck at 0, expected = 16'hDF03 → captured = 16'h0000, mismatch_count = 9, first_fail = 0, fail_valid = 1, pass = 0.
- Golden model with minterm 13 also asserted → captured = 16'hFF03, mismatch_count = 1, first_fail = 13, pass = 0.
- Second start and expected changed to 16'h0000 during the sweep (idx = 5) → both ignored; results identical to the first scenario; done still at E0+16.
- rst asserted when idx = 7 → next cycle all outputs at reset values. New start then completes a full clean sweep with pass = 1.
- S = 3, golden model → each vector held 3 cycles, F sampled at edges E0+3, +6, …, +48. done after E0+48, pass = 1. Restart from DONE clears results on the accept edge.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 4-input combinational block through all 16
// input vectors, records its output per vector and compares the observed
// truth table against a latched expected minterm mask.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail,
  output logic        fail_valid
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned MIS_W = 5;
  localparam int unsigned TBL_W = 16;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TBL_W-1:0] exp_q, exp_d;
  logic [TBL_W-1:0] cap_d;
  logic [MIS_W-1:0] mis_d, mis_inc;
  logic [IDX_W-1:0] ff_d;
  logic             fv_d, busy_d, done_d, pass_d;
  logic             sample_miss;

  // The driven vector is the current index register itself
  assign {A, B, C, D} = idx_q;

  // Next-state and next-result computation
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    cap_d    = captured;
    mis_d    = mismatch_count;
    ff_d     = first_fail;
    fv_d     = fail_valid;
    busy_d   = busy;
    done_d   = done;
    pass_d   = pass;
    sample_miss = F ^ exp_q[idx_q];
    mis_inc     = mismatch_count + MIS_W'(sample_miss);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          exp_d   = expected;
          cap_d   = '0;
          mis_d   = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cap_d[idx_q] = F;
          mis_d        = mis_inc;
          if (sample_miss && !fail_valid) begin
            ff_d = idx_q;
            fv_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            // pass must include the vector sampled on this same edge
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mis_inc == '0);
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      exp_q          <= '0;
      captured       <= '0;
      mismatch_count <= '0;
      first_fail     <= '0;
      fail_valid     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      exp_q          <= exp_d;
      captured       <= cap_d;
      mismatch_count <= mis_d;
      first_fail     <= ff_d;
      fail_valid     <= fv_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
    end
  end

endmodule
